// File: rtl/lx32_wb_pkg.sv
// Shared constants and types for the register-file write-back controller.
package lx32_wb_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Enum value doubles as the bit position in the arbiter grant vector.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bus bundle between the ALU/LSU/decode side and the write-back controller.
interface regfile_wb_ctrl_if;
    import lx32_wb_pkg::*;

    // Handshake: a transfer happens at a clock edge where valid & ready are both 1;
    // the requester holds valid, rd and data stable until it sees ready.
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;

    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;
    logic [REG_AW-1:0] query_rs1;
    logic [REG_AW-1:0] query_rs2;
    logic              hazard;

    logic [REG_AW-1:0] addr_rd;
    logic [XLEN-1:0]   data_rd;
    logic              we;

    // Observation only: scoreboard contents and arbiter next-pointer.
    logic [NREG-1:0]   pend;
    logic              rr_ptr;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, query_rs1, query_rs2,
        input  alu_ready, lsu_ready, hazard,
        input  addr_rd, data_rd, we, pend, rr_ptr
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, query_rs1, query_rs2,
        output alu_ready, lsu_ready, hazard,
        output addr_rd, data_rd, we, pend, rr_ptr
    );
endinterface

// File: rtl/wb_rr_arb2.sv
// Two-requester write-back arbiter. LX32_WB_RR_ARB_EN selects round-robin;
// otherwise LSU has fixed priority and no pointer flop exists.
module wb_rr_arb2
    import lx32_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       ptr_nxt_o
);

`ifdef LX32_WB_RR_ARB_EN
    // ptr_q = 1 means LSU is favoured on the next contended cycle.
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = req_i;
        ptr_d = ptr_q;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_nxt_o = ptr_d;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign gnt_o = req_i[WB_LSU] ? 2'b10 : req_i;
    assign ptr_nxt_o = 1'b1;
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU/LSU onto the registered regfile write
// port and tracks pending writes for decode hazards (LX32_WB_RR_ARB_EN: round-robin).
module regfile_wb_ctrl
    import lx32_wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    regfile_wb_ctrl_if.slave        wb
);

    logic [1:0]        gnt;
    logic              xfer;
    logic              hazard;
    wb_req_t           alu_req;
    wb_req_t           lsu_req;
    wb_req_t           win_req;

    logic              we_q, we_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [NREG-1:0]   pend_q, pend_d;

    wb_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({wb.lsu_valid, wb.alu_valid}),
        .gnt_o     (gnt),
        .ptr_nxt_o (wb.rr_ptr)
    );

    assign alu_req = '{rd: wb.alu_rd, data: wb.alu_data};
    assign lsu_req = '{rd: wb.lsu_rd, data: wb.lsu_data};
    assign win_req = gnt[WB_LSU] ? lsu_req : alu_req;
    assign xfer    = |gnt;

    assign wb.alu_ready = gnt[WB_ALU];
    assign wb.lsu_ready = gnt[WB_LSU];

    // No forwarding: a pending bit stays set through the commit cycle.
    assign hazard = pend_q[wb.query_rs1] | pend_q[wb.query_rs2] |
                    (wb.issue_valid & pend_q[wb.issue_rd]);
    assign wb.hazard = hazard;

    always_comb begin
        we_d   = xfer && (win_req.rd != '0);
        addr_d = xfer ? win_req.rd : addr_q;
        data_d = xfer ? win_req.data : data_q;

        // Clear first so a same-index set takes priority.
        pend_d = pend_q;
        if (we_q) begin
            pend_d[addr_q] = 1'b0;
        end
        if (wb.issue_valid && !hazard && (wb.issue_rd != '0)) begin
            pend_d[wb.issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            pend_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign wb.we      = we_q;
    assign wb.addr_rd = addr_q;
    assign wb.data_rd = data_q;
    assign wb.pend    = pend_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed vectors, a behavioural
// model compared every cycle, and literal expectations at key points.
module tb_regfile_wb_ctrl;
    import lx32_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_wb_ctrl_if bus ();

    regfile_wb_ctrl dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit              m_pend [NREG];
    bit              m_we = 1'b0;
    bit [REG_AW-1:0] m_addr = '0;
    bit [XLEN-1:0]   m_data = '0;
    bit              m_lsu_turn = 1'b1;

    function automatic bit [1:0] m_grant();
        if (bus.alu_valid && bus.lsu_valid) begin
`ifdef LX32_WB_RR_ARB_EN
            return m_lsu_turn ? 2'b10 : 2'b01;
`else
            return 2'b10;
`endif
        end
        return {bus.lsu_valid, bus.alu_valid};
    endfunction

    function automatic bit m_hazard();
        return m_pend[bus.query_rs1] || m_pend[bus.query_rs2] ||
               (bus.issue_valid && m_pend[bus.issue_rd]);
    endfunction

    function automatic logic [NREG-1:0] m_pend_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        bit [1:0] g;
        bit       h;
        if (!rst) begin
            for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            m_we = 1'b0; m_addr = '0; m_data = '0; m_lsu_turn = 1'b1;
        end else begin
            g = m_grant();
            h = m_hazard();
            if (m_we) m_pend[m_addr] = 1'b0;
            if (bus.issue_valid && !h && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
            if (g != 2'b00) begin
                m_addr = g[1] ? bus.lsu_rd : bus.alu_rd;
                m_data = g[1] ? bus.lsu_data : bus.alu_data;
                m_we   = (m_addr != 0);
            end else begin
                m_we = 1'b0;
            end
            if (bus.alu_valid && bus.lsu_valid) m_lsu_turn = ~m_lsu_turn;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit [1:0] g;
        if (rst) begin
            g = m_grant();
            chk("alu_ready", bus.alu_ready, g[0]);
            chk("lsu_ready", bus.lsu_ready, g[1]);
            chk("hazard", bus.hazard, m_hazard());
            chk("we", bus.we, m_we);
            chk("addr_rd", bus.addr_rd, m_addr);
            chk("data_rd", bus.data_rd, m_data);
            chk("pend", bus.pend, m_pend_vec());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.query_rs1 = '0; bus.query_rs2 = '0;
    endtask

    bit exp_lsu [4];

    initial begin
`ifdef LX32_WB_RR_ARB_EN
        exp_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        idle_inputs();
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset then idle
        @(negedge clk);
        chk("rst_we", bus.we, 1'b0);
        chk("rst_addr", bus.addr_rd, 0);
        chk("rst_data", bus.data_rd, 0);
        chk("rst_hazard", bus.hazard, 1'b0);
        chk("rst_alu_ready", bus.alu_ready, 1'b0);
        chk("rst_lsu_ready", bus.lsu_ready, 1'b0);

        // ALU only
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("alu_only_ready", bus.alu_ready, 1'b1);
        step();
        bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_only_we", bus.we, 1'b1);
        chk("alu_only_addr", bus.addr_rd, 5);
        chk("alu_only_data", bus.data_rd, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("alu_only_we_off", bus.we, 1'b0);

        // Scoreboard RAW sequence
        step();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        step();
        bus.issue_rd = 5'd7; bus.query_rs1 = 5'd7;
        @(negedge clk);
        chk("raw_pend7", bus.pend[7], 1'b1);
        chk("raw_hazard", bus.hazard, 1'b1);
        step();
        bus.issue_rd = 5'd9;
        @(negedge clk);
        chk("raw_issue_blocked_hazard", bus.hazard, 1'b1);
        step();
        bus.issue_valid = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0077;
        @(negedge clk);
        chk("raw_ignored_issue9", bus.pend[9], 1'b0);
        chk("raw_lsu_ready", bus.lsu_ready, 1'b1);
        chk("raw_hazard_pre", bus.hazard, 1'b1);
        step();
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        chk("raw_commit_we", bus.we, 1'b1);
        chk("raw_commit_addr", bus.addr_rd, 7);
        chk("raw_hazard_commit", bus.hazard, 1'b1);
        step();
        @(negedge clk);
        chk("raw_hazard_after", bus.hazard, 1'b0);
        chk("raw_pend7_clear", bus.pend[7], 1'b0);
        bus.query_rs1 = '0;

        // Contention, four cycles, distinct rd
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA000_0010;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'hB000_0011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_lsu_ready", bus.lsu_ready, exp_lsu[i]);
            chk("cont_alu_ready", bus.alu_ready, !exp_lsu[i]);
            step();
            if (exp_lsu[i]) begin
                bus.lsu_rd = bus.lsu_rd + 5'd2; bus.lsu_data = bus.lsu_data + 32'd2;
            end else begin
                bus.alu_rd = bus.alu_rd + 5'd2; bus.alu_data = bus.alu_data + 32'd2;
            end
        end
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        step();

        // rd = 0 requests and queries
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.query_rs1 = 5'd0;
        @(negedge clk);
        chk("rd0_alu_ready", bus.alu_ready, 1'b1);
        chk("rd0_hazard", bus.hazard, 1'b0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("rd0_we", bus.we, 1'b0);
        chk("rd0_pend", bus.pend, 0);

        // Mid-operation asynchronous reset
        step();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        step();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
        step();
        bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_we", bus.we, 1'b1);
        chk("mid_pre_pend3", bus.pend[3], 1'b1);
        #2 rst = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_we", bus.we, 1'b0);
        chk("mid_rst_pend", bus.pend, 0);
        chk("mid_rst_addr", bus.addr_rd, 0);
        step();
        rst = 1'b1;
        bus.query_rs1 = 5'd3;
        @(negedge clk);
        chk("mid_post_hazard", bus.hazard, 1'b0);

        step();
        idle_inputs();
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
